// File: rtl/initialization_command_sequencer_if.sv
// Write-side and command-word-enable signals between the CPU write path, the
// initialization command sequencer and the command word registers.
interface initialization_command_sequencer_if;
    logic       write_strobe;
    logic       address_0;
    logic [7:0] internal_data_bus;
    logic [7:0] command_data;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2;
    logic       write_initial_command_word_3;
    logic       write_initial_command_word_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic       initialization_in_progress;
    logic       end_of_initialization;

    modport master (
        output write_strobe, address_0, internal_data_bus,
        input  command_data,
        input  write_initial_command_word_1, write_initial_command_word_2,
        input  write_initial_command_word_3, write_initial_command_word_4,
        input  write_operation_control_word_1, write_operation_control_word_2,
        input  write_operation_control_word_3,
        input  initialization_in_progress, end_of_initialization
    );

    modport slave (
        input  write_strobe, address_0, internal_data_bus,
        output command_data,
        output write_initial_command_word_1, write_initial_command_word_2,
        output write_initial_command_word_3, write_initial_command_word_4,
        output write_operation_control_word_1, write_operation_control_word_2,
        output write_operation_control_word_3,
        output initialization_in_progress, end_of_initialization
    );
endinterface

// File: rtl/initialization_command_sequencer.sv
// 8259A command decoder: classifies CPU writes as ICW1-4 / OCW1-3, runs the
// initialization sequence and emits registered one-cycle write enables.
module initialization_command_sequencer #(
    parameter bit IGNORE_WRITES_BEFORE_ICW1 = 1'b1
) (
    input logic                                clock,
    input logic                                reset_n,
    initialization_command_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        StWaitIcw1,
        StWaitIcw2,
        StWaitIcw3,
        StWaitIcw4,
        StReady
    } state_e;

    localparam int unsigned PIcw1 = 0;
    localparam int unsigned PIcw2 = 1;
    localparam int unsigned PIcw3 = 2;
    localparam int unsigned PIcw4 = 3;
    localparam int unsigned POcw1 = 4;
    localparam int unsigned POcw2 = 5;
    localparam int unsigned POcw3 = 6;

    state_e     state_q, state_d;
    logic       cascade_q, cascade_d;
    logic       icw4_needed_q, icw4_needed_d;
    logic       in_progress_q, in_progress_d;
    logic       eoi_q, eoi_d;
    logic [6:0] pulse_q, pulse_d;
    logic [7:0] data_q, data_d;
    logic       is_icw1;
    logic       decode_ocw;

    assign is_icw1 = ~bus.address_0 & bus.internal_data_bus[4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StWaitIcw1;
            cascade_q     <= 1'b0;
            icw4_needed_q <= 1'b0;
            in_progress_q <= 1'b0;
            eoi_q         <= 1'b0;
            pulse_q       <= '0;
            data_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            cascade_q     <= cascade_d;
            icw4_needed_q <= icw4_needed_d;
            in_progress_q <= in_progress_d;
            eoi_q         <= eoi_d;
            pulse_q       <= pulse_d;
            data_q        <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cascade_d     = cascade_q;
        icw4_needed_d = icw4_needed_q;
        in_progress_d = in_progress_q;
        eoi_d         = 1'b0;
        pulse_d       = '0;
        decode_ocw    = 1'b0;
        data_d        = bus.write_strobe ? bus.internal_data_bus : data_q;

        if (bus.write_strobe) begin
            if (is_icw1) begin
                // ICW1 restarts the sequence from any state; SNGL=0 means cascade.
                pulse_d[PIcw1] = 1'b1;
                cascade_d      = ~bus.internal_data_bus[1];
                icw4_needed_d  = bus.internal_data_bus[0];
                in_progress_d  = 1'b1;
                state_d        = StWaitIcw2;
            end else begin
                case (state_q)
                    StWaitIcw1: decode_ocw = ~IGNORE_WRITES_BEFORE_ICW1;
                    StWaitIcw2: begin
                        if (bus.address_0) begin
                            pulse_d[PIcw2] = 1'b1;
                            if (cascade_q)          state_d = StWaitIcw3;
                            else if (icw4_needed_q) state_d = StWaitIcw4;
                            else                    state_d = StReady;
                        end
                    end
                    StWaitIcw3: begin
                        if (bus.address_0) begin
                            pulse_d[PIcw3] = 1'b1;
                            state_d        = icw4_needed_q ? StWaitIcw4 : StReady;
                        end
                    end
                    StWaitIcw4: begin
                        if (bus.address_0) begin
                            pulse_d[PIcw4] = 1'b1;
                            state_d        = StReady;
                        end
                    end
                    StReady:    decode_ocw = 1'b1;
                    default:    state_d = StWaitIcw1;
                endcase

                // D4 is known to be 0 here whenever A0=0, since ICW1 was excluded.
                if (decode_ocw) begin
                    if (bus.address_0)                  pulse_d[POcw1] = 1'b1;
                    else if (bus.internal_data_bus[3])  pulse_d[POcw3] = 1'b1;
                    else                                pulse_d[POcw2] = 1'b1;
                end

                if (state_q != StReady && state_q != StWaitIcw1 && state_d == StReady) begin
                    eoi_d         = 1'b1;
                    in_progress_d = 1'b0;
                end
            end
        end
    end

    assign bus.command_data                   = data_q;
    assign bus.write_initial_command_word_1   = pulse_q[PIcw1];
    assign bus.write_initial_command_word_2   = pulse_q[PIcw2];
    assign bus.write_initial_command_word_3   = pulse_q[PIcw3];
    assign bus.write_initial_command_word_4   = pulse_q[PIcw4];
    assign bus.write_operation_control_word_1 = pulse_q[POcw1];
    assign bus.write_operation_control_word_2 = pulse_q[POcw2];
    assign bus.write_operation_control_word_3 = pulse_q[POcw3];
    assign bus.initialization_in_progress     = in_progress_q;
    assign bus.end_of_initialization          = eoi_q;
endmodule

// File: tb/tb_initialization_command_sequencer.sv
// Directed bench for initialization_command_sequencer: one task per scenario,
// observed outputs packed as {icw1..icw4, ocw1..ocw3, eoi, in_progress}.
module tb_initialization_command_sequencer;
    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    initialization_command_sequencer_if bus ();

    initialization_command_sequencer #(
        .IGNORE_WRITES_BEFORE_ICW1(1'b1)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    localparam logic [8:0] NONE = 9'b0000000_0_0;
    localparam logic [8:0] IP   = 9'b0000000_0_1;
    localparam logic [8:0] ICW1 = 9'b1000000_0_0;
    localparam logic [8:0] ICW2 = 9'b0100000_0_0;
    localparam logic [8:0] ICW3 = 9'b0010000_0_0;
    localparam logic [8:0] ICW4 = 9'b0001000_0_0;
    localparam logic [8:0] OCW1 = 9'b0000100_0_0;
    localparam logic [8:0] OCW2 = 9'b0000010_0_0;
    localparam logic [8:0] OCW3 = 9'b0000001_0_0;
    localparam logic [8:0] EOI  = 9'b0000000_1_0;

    logic [8:0] obs;
    assign obs = {bus.write_initial_command_word_1, bus.write_initial_command_word_2,
                  bus.write_initial_command_word_3, bus.write_initial_command_word_4,
                  bus.write_operation_control_word_1, bus.write_operation_control_word_2,
                  bus.write_operation_control_word_3, bus.end_of_initialization,
                  bus.initialization_in_progress};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One write; returns at the negedge where that write's result is visible.
    task automatic wr(input logic a0, input logic [7:0] d);
        @(negedge clock);
        bus.write_strobe      = 1'b1;
        bus.address_0         = a0;
        bus.internal_data_bus = d;
        @(negedge clock);
        bus.write_strobe      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        tests++;
        if (obs !== NONE || bus.command_data !== 8'h00) begin
            fails++;
            $display("FAIL reset obs=%b cmd=%h exp obs=%b cmd=00", obs, bus.command_data, NONE);
        end
    endtask

    task automatic test_single_no_icw4();
        logic [8:0] exp_o [3] = '{ICW1 | IP, ICW2 | EOI, OCW1};
        logic [7:0] exp_d [3] = '{8'h12, 8'h40, 8'h55};
        logic       a0    [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            wr(a0[i], exp_d[i]);
            tests++;
            if (obs !== exp_o[i] || bus.command_data !== exp_d[i]) begin
                fails++;
                $display("FAIL single[%0d] obs=%b cmd=%h exp obs=%b cmd=%h",
                         i, obs, bus.command_data, exp_o[i], exp_d[i]);
            end
        end
        @(negedge clock);
        tests++;
        if (obs !== NONE || bus.command_data !== 8'h55) begin
            fails++;
            $display("FAIL idle_no_pulse obs=%b cmd=%h exp obs=%b cmd=55", obs, bus.command_data, NONE);
        end
    endtask

    task automatic test_cascade_icw4();
        logic [8:0] exp_o [4] = '{ICW1 | IP, ICW2 | IP, ICW3 | IP, ICW4 | EOI};
        logic [7:0] exp_d [4] = '{8'h11, 8'h20, 8'h04, 8'h01};
        logic       a0    [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            wr(a0[i], exp_d[i]);
            tests++;
            if (obs !== exp_o[i] || bus.command_data !== exp_d[i]) begin
                fails++;
                $display("FAIL cascade[%0d] obs=%b cmd=%h exp obs=%b cmd=%h",
                         i, obs, bus.command_data, exp_o[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_ocw_decode();
        logic [8:0] exp_o [3] = '{OCW1, OCW2, OCW3};
        logic [7:0] exp_d [3] = '{8'hFB, 8'h20, 8'h0A};
        logic       a0    [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            wr(a0[i], exp_d[i]);
            tests++;
            if (obs !== exp_o[i] || bus.command_data !== exp_d[i]) begin
                fails++;
                $display("FAIL ocw[%0d] obs=%b cmd=%h exp obs=%b cmd=%h",
                         i, obs, bus.command_data, exp_o[i], exp_d[i]);
            end
        end
    endtask

    // 8'h13 recaptures single mode with ICW4, so the restart runs ICW2 -> ICW4.
    task automatic test_restart();
        logic [8:0] exp_o [5] = '{ICW1 | IP, ICW2 | IP, ICW1 | IP, ICW2 | IP, ICW4 | EOI};
        logic [7:0] exp_d [5] = '{8'h11, 8'h20, 8'h13, 8'hAA, 8'h01};
        logic       a0    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            wr(a0[i], exp_d[i]);
            tests++;
            if (obs !== exp_o[i] || bus.command_data !== exp_d[i]) begin
                fails++;
                $display("FAIL restart[%0d] obs=%b cmd=%h exp obs=%b cmd=%h",
                         i, obs, bus.command_data, exp_o[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_junk_writes();
        logic [8:0] exp_o [5] = '{NONE, NONE, ICW1 | IP, IP, ICW2 | EOI};
        logic [7:0] exp_d [5] = '{8'hFF, 8'h08, 8'h12, 8'h08, 8'h40};
        logic       a0    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr(a0[i], exp_d[i]);
            tests++;
            if (obs !== exp_o[i] || bus.command_data !== exp_d[i]) begin
                fails++;
                $display("FAIL junk[%0d] obs=%b cmd=%h exp obs=%b cmd=%h",
                         i, obs, bus.command_data, exp_o[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        tests++;
        if (obs !== (ICW2 | IP) || bus.command_data !== 8'h20) begin
            fails++;
            $display("FAIL pre_async obs=%b cmd=%h exp obs=%b cmd=20", obs, bus.command_data, ICW2 | IP);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (obs !== NONE || bus.command_data !== 8'h00) begin
            fails++;
            $display("FAIL async_reset obs=%b cmd=%h exp obs=%b cmd=00", obs, bus.command_data, NONE);
        end
        @(negedge clock);
        reset_n = 1'b1;
        wr(1'b1, 8'h04);
        tests++;
        if (obs !== NONE || bus.command_data !== 8'h04) begin
            fails++;
            $display("FAIL post_reset_write obs=%b cmd=%h exp obs=%b cmd=04", obs, bus.command_data, NONE);
        end
    endtask

    // Strobe held high across consecutive cycles; each cycle's result checked.
    task automatic test_back_to_back();
        logic [8:0] exp_o [4] = '{ICW1 | IP, ICW2 | EOI, OCW2, OCW3};
        logic [7:0] exp_d [4] = '{8'h12, 8'h40, 8'h20, 8'h0A};
        logic       a0    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            bus.write_strobe      = 1'b1;
            bus.address_0         = a0[i];
            bus.internal_data_bus = exp_d[i];
            @(negedge clock);
            tests++;
            if (obs !== exp_o[i] || bus.command_data !== exp_d[i]) begin
                fails++;
                $display("FAIL b2b[%0d] obs=%b cmd=%h exp obs=%b cmd=%h",
                         i, obs, bus.command_data, exp_o[i], exp_d[i]);
            end
        end
        bus.write_strobe = 1'b0;
        @(negedge clock);
        tests++;
        if (obs !== NONE) begin
            fails++;
            $display("FAIL b2b_tail obs=%b exp obs=%b", obs, NONE);
        end
    endtask

    initial begin
        tests                 = 0;
        fails                 = 0;
        reset_n               = 1'b0;
        bus.write_strobe      = 1'b0;
        bus.address_0         = 1'b0;
        bus.internal_data_bus = 8'h00;
        repeat (2) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_single_no_icw4();
        test_cascade_icw4();
        test_ocw_decode();
        test_restart();
        test_junk_writes();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
